fft_sample_buffer: RTL and testbench

//  Sample/result memory between the AXI bridge and the FFT core. Stores 16-bit real samples

---
 rtl/fft_sample_buffer.sv | 151 +++++++++++++++
 tb/tb_fft_sample_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_buffer.sv
// Sample/result memory between the AXI bridge and the FFT core.
// Frame FSM LOAD -> COMPUTE -> UNLOAD arbitrates a single memory between the two ports.
module fft_sample_buffer #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_WRITE_ram,
  input  logic                    i_READ_ram,
  input  logic [11:0]             i_SAMPLE_INDEX_ram,
  input  logic [SAMPLE_WIDTH-1:0] i_SAMPLE_ram,
  input  logic                    i_DATA_LOADED,
  output logic [DATA_WIDTH-1:0]   o_DATA_FROM_RAM,
  output logic                    o_CALC_END,
  output logic [11:0]             o_SAMPLES_NUMBER,
  output logic                    o_START,
  input  logic [ADDR_WIDTH-1:0]   i_core_addr,
  input  logic                    i_core_rd,
  input  logic                    i_core_wr,
  input  logic [DATA_WIDTH-1:0]   i_core_wdata,
  output logic [DATA_WIDTH-1:0]   o_core_rdata,
  input  logic                    i_core_done,
  output logic                    o_ERR
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned IDX_W = 12;
  localparam int unsigned IM_W  = DATA_WIDTH - SAMPLE_WIDTH;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  state_t                  state, state_d;
  logic                    start_d, calc_end_d, err_d, rd_en;
  logic [IDX_W-1:0]        nsamp_d;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    idx_ok;
  logic [ADDR_WIDTH-1:0]   idx_lo;
  logic [IDX_W-1:0]        idx_next;
  logic [DATA_WIDTH-1:0]   sample_word;
  logic                    unused_read;

  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < int'(ADDR_WIDTH); i++) r[i] = a[int'(ADDR_WIDTH)-1-i];
    return r;
  endfunction

  // Bridge reads are purely combinational, so the read strobe carries no state.
  assign unused_read = i_READ_ram;

  assign idx_ok      = 32'(i_SAMPLE_INDEX_ram) < DEPTH;
  assign idx_lo      = i_SAMPLE_INDEX_ram[ADDR_WIDTH-1:0];
  assign idx_next    = i_SAMPLE_INDEX_ram + IDX_W'(1);
  assign sample_word = {i_SAMPLE_ram, IM_W'(0)};

  // Next-state, next-output and single memory write port selection.
  always_comb begin
    state_d    = state;
    start_d    = 1'b0;
    calc_end_d = o_CALC_END;
    nsamp_d    = o_SAMPLES_NUMBER;
    err_d      = o_ERR;
    rd_en      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    unique case (state)
      ST_LOAD: begin
        if (i_WRITE_ram) begin
          if (idx_ok) begin
            mem_we    = 1'b1;
            mem_waddr = bitrev(idx_lo);
            mem_wdata = sample_word;
            if (idx_next > o_SAMPLES_NUMBER) nsamp_d = idx_next;
          end else begin
            err_d = 1'b1;
          end
        end
        if (i_DATA_LOADED) begin
          state_d = ST_COMPUTE;
          start_d = 1'b1;
        end
      end
      ST_COMPUTE: begin
        rd_en = i_core_rd;
        if (i_core_wr) begin
          mem_we    = 1'b1;
          mem_waddr = i_core_addr;
          mem_wdata = i_core_wdata;
        end
        if (i_core_done) begin
          state_d    = ST_UNLOAD;
          calc_end_d = 1'b1;
        end
      end
      ST_UNLOAD: begin
        // A bridge write here opens the next frame and is its first sample.
        if (i_WRITE_ram) begin
          state_d    = ST_LOAD;
          calc_end_d = 1'b0;
          if (idx_ok) begin
            mem_we    = 1'b1;
            mem_waddr = bitrev(idx_lo);
            mem_wdata = sample_word;
            nsamp_d   = idx_next;
          end else begin
            err_d   = 1'b1;
            nsamp_d = '0;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state            <= ST_LOAD;
      o_START          <= 1'b0;
      o_CALC_END       <= 1'b0;
      o_SAMPLES_NUMBER <= '0;
      o_ERR            <= 1'b0;
      o_core_rdata     <= '0;
    end else begin
      state            <= state_d;
      o_START          <= start_d;
      o_CALC_END       <= calc_end_d;
      o_SAMPLES_NUMBER <= nsamp_d;
      o_ERR            <= err_d;
      if (rd_en) o_core_rdata <= mem[i_core_addr];
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign o_DATA_FROM_RAM = (state == ST_UNLOAD && idx_ok) ? mem[idx_lo] : '0;

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Scoreboard bench for fft_sample_buffer: stimulus pushes expected outputs from a frame-level
// model into a queue, a negedge monitor pops and compares them.
module tb_fft_sample_buffer;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_ram = 1'b0, rd_ram = 1'b0, data_loaded = 1'b0;
  logic [11:0] sidx = '0;
  logic [15:0] sample = '0;
  logic [31:0] from_ram;
  logic        calc_end, start, err;
  logic [11:0] nsamp;
  logic [2:0]  core_addr = '0;
  logic        core_rd = 1'b0, core_wr = 1'b0, core_done = 1'b0;
  logic [31:0] core_wdata = '0, core_rdata;

  fft_sample_buffer #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .SAMPLE_WIDTH(16)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_WRITE_ram(wr_ram), .i_READ_ram(rd_ram),
    .i_SAMPLE_INDEX_ram(sidx), .i_SAMPLE_ram(sample), .i_DATA_LOADED(data_loaded),
    .o_DATA_FROM_RAM(from_ram), .o_CALC_END(calc_end), .o_SAMPLES_NUMBER(nsamp),
    .o_START(start),
    .i_core_addr(core_addr), .i_core_rd(core_rd), .i_core_wr(core_wr),
    .i_core_wdata(core_wdata), .o_core_rdata(core_rdata), .i_core_done(core_done),
    .o_ERR(err)
  );

  always #5 clk = ~clk;

  typedef enum int {K_RDATA, K_FROM_RAM, K_CALC_END, K_NSAMP, K_START, K_ERR} kind_t;
  typedef struct {
    int          due;
    kind_t       kind;
    logic [31:0] exp;
  } item_t;

  item_t exp_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  // Frame-level reference model: phase 0 = loading, 1 = core busy, 2 = results out.
  logic [31:0] m_mem [DEPTH];
  int          m_phase = 0;
  int          m_nsamp = 0;
  bit          m_err = 0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input kind_t k);
    case (k)
      K_RDATA:    return "core_rdata";
      K_FROM_RAM: return "data_from_ram";
      K_CALC_END: return "calc_end";
      K_NSAMP:    return "samples_number";
      K_START:    return "start";
      default:    return "err";
    endcase
  endfunction

  function automatic logic [31:0] actual(input kind_t k);
    case (k)
      K_RDATA:    return core_rdata;
      K_FROM_RAM: return from_ram;
      K_CALC_END: return 32'(calc_end);
      K_NSAMP:    return 32'(nsamp);
      K_START:    return 32'(start);
      default:    return 32'(err);
    endcase
  endfunction

  // Monitor: compares every expectation that has come due this cycle.
  always @(negedge clk) begin
    item_t       it;
    logic [31:0] act;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      it  = exp_q.pop_front();
      act = actual(it.kind);
      n_checks++;
      if (it.due != cyc || act !== it.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d (due %0d): got %h expected %h",
                 kname(it.kind), cyc, it.due, act, it.exp);
      end
    end
  end

  function automatic int rev(input int a);
    int r = 0;
    for (int b = 0; b < AW; b++) if (((a >> b) & 1) != 0) r += 1 << (AW - 1 - b);
    return r;
  endfunction

  task automatic push(input int due, input kind_t k, input logic [31:0] e);
    item_t it;
    it.due = due; it.kind = k; it.exp = e;
    exp_q.push_back(it);
  endtask

  task automatic push_regs(input int due, input bit st);
    push(due, K_RDATA, m_rdata);
    push(due, K_CALC_END, 32'(m_phase == 2));
    push(due, K_NSAMP, 32'(m_nsamp));
    push(due, K_START, 32'(st));
    push(due, K_ERR, 32'(m_err));
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input bit w, input int idx, input logic [15:0] smp, input bit ld,
                      input bit crd, input bit cwr, input int caddr, input logic [31:0] cwd,
                      input bit cdone);
    int c = cyc;
    int p = m_phase;
    bit st = 0;
    wr_ram = w; sidx = 12'(idx); sample = smp; data_loaded = ld;
    rd_ram = 1'($urandom_range(0, 1));
    core_rd = crd; core_wr = cwr; core_addr = 3'(caddr); core_wdata = cwd; core_done = cdone;
    push(c, K_FROM_RAM, (p == 2 && idx < DEPTH) ? m_mem[idx] : 32'h0);
    if (p == 0 || (p == 2 && w)) begin
      if (p == 2) begin m_phase = 0; m_nsamp = 0; end
      if (w) begin
        if (idx < DEPTH) begin
          m_mem[rev(idx)] = {smp, 16'h0};
          if (idx + 1 > m_nsamp) m_nsamp = idx + 1;
        end else m_err = 1;
      end
      if (p == 0 && ld) begin m_phase = 1; st = 1; end
    end else if (p == 1) begin
      if (crd) m_rdata = m_mem[caddr];
      if (cwr) m_mem[caddr] = cwd;
      if (cdone) m_phase = 2;
    end
    push_regs(c + 1, st);
    @(posedge clk); #1;
  endtask

  task automatic bwrite(input int idx, input logic [15:0] smp, input bit ld);
    step(1, idx, smp, ld, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic bread(input int idx);
    step(0, idx, 16'h0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic core(input bit crd, input bit cwr, input int a, input logic [31:0] d,
                      input bit dn);
    step(0, 0, 16'h0, 0, crd, cwr, a, d, dn);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rstn = 1'b0;
    wr_ram = 0; data_loaded = 0; core_rd = 0; core_wr = 0; core_done = 0;
    m_phase = 0; m_nsamp = 0; m_err = 0; m_rdata = '0;
    @(posedge clk); #1;
    push(cyc, K_FROM_RAM, 32'h0);
    push_regs(cyc, 0);
    rstn = 1'b1;
  endtask

  initial begin
    do_reset();

    // Directed frame: samples 1..8 at indices 0..7.
    for (int i = 0; i < DEPTH; i++) bwrite(i, 16'(i + 1), i == DEPTH - 1);
    core(1, 0, 4, 32'h0, 0);
    core(1, 1, 4, 32'hAAAA_5555, 0);
    core(1, 0, 4, 32'h0, 0);
    step(1, 0, 16'h1234, 0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < DEPTH; i++) core(1, 0, i, 32'h0, 0);
    for (int i = 0; i < 6; i++)
      core(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           $urandom, 0);
    core(0, 1, 6, 32'hC0DE_0006, 1);
    bread(4);
    bread(9);
    for (int i = 0; i < DEPTH; i++) bread(i);
    bwrite(2, 16'h0007, 0);
    bwrite(12, 16'hFFFF, 0);
    bwrite(1, 16'h0011, 0);
    bwrite(0, 16'h0022, 1);
    core(1, 0, 2, 32'h0, 0);
    core(0, 1, 3, 32'h1357_9BDF, 0);

    // Reset mid-compute, then confirm memory survived.
    do_reset();
    step(0, 0, 16'h0, 1, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < DEPTH; i++) core(1, 0, i, 32'h0, 0);
    core(0, 0, 0, 32'h0, 1);
    for (int i = 0; i < DEPTH; i++) bread(i);

    // Randomised frames.
    for (int f = 0; f < 4; f++) begin
      bwrite(int'($urandom_range(0, 7)), 16'($urandom), 0);
      for (int i = 0; i < int'($urandom_range(1, 8)); i++)
        bwrite(int'($urandom_range(0, 9)), 16'($urandom), 0);
      step(0, 0, 16'h0, 0, 1, 1, 0, 32'h0, 1);
      bwrite(int'($urandom_range(0, 8)), 16'($urandom), 1);
      for (int i = 0; i < 10; i++)
        step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom), 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), $urandom, 0);
      core(1'($urandom_range(0, 1)), 1, int'($urandom_range(0, 7)), $urandom, 1);
      for (int i = 0; i < 6; i++) bread(int'($urandom_range(0, 10)));
    end

    core(0, 0, 0, 32'h0, 0);
    core(0, 0, 0, 32'h0, 0);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
